seg7_capture: RTL and testbench

Seven-segment display reader: samples a multiplexed, active-low 7-segment display bus (segments plus digit-select strobes), waits for each digit pattern to be stable, decodes it back to BCD and assembles a full multi-digit frame. It is the receive end of the team's BCD-to-segment display path and is used for loopback self-test and for scraping values from external display drivers. A one-cycle `frame_valid` pulse qualifies each completed frame on `value`.

---
 rtl/seg7_capture.sv | 175 +++++++++++++++++
 tb/tb_seg7_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: receive end of a multiplexed active-low 7-segment display bus.
// Each {an,seg} sample must stay identical for STABLE_CYCLES edges before the
// selected digit is decoded back to BCD and written into its slot. Once every
// slot has been seen, the slots are published on value with a one-cycle
// frame_valid pulse and err flags any undecodable pattern in the frame.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int SW    = DIGITS + 7;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SW-1:0]       r_sample;
  logic [SW-1:0]       w_sample;
  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_nxt;
  logic [DIGITS-1:0]   r_seen;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic [4*DIGITS-1:0] r_slot_val;
  logic [DIGITS-1:0]   r_slot_err;
  logic [DIGITS-1:0]   w_slot_err_nxt;
  logic [3:0]          w_nlow;
  logic [IDX_W-1:0]    w_idx;
  logic                w_valid;
  logic                w_match;
  logic                w_commit;
  logic                w_full;
  logic [4:0]          w_dec;

  // Segment pattern to {error, nibble}; all-dark is a legal blank digit (F).
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b1111111: return 5'h0F;
      default:    return 5'h1E;
    endcase
  endfunction

  assign w_sample = {an, seg};
  assign w_match  = (w_sample == r_sample);
  assign w_dec    = seg_decode(seg);
  assign w_full   = &r_seen;

  // Count the low strobes and remember which digit is selected.
  always_comb begin
    w_nlow = 4'd0;
    w_idx  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!an[k]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = IDX_W'(k);
      end
    end
    w_valid = (w_nlow == 4'd1);
  end

  // Stability counter: restart on change, clear on invalid strobes, saturate.
  always_comb begin
    w_cnt_nxt = 8'd1;
    if (!w_valid) begin
      w_cnt_nxt = 8'd0;
    end else if (w_match) begin
      w_cnt_nxt = (r_cnt >= SC) ? SC : r_cnt + 8'd1;
    end
  end

  // FSM next state: one commit per stable period, re-armed by any change.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      TRACK: begin
        if (w_valid && (w_cnt_nxt == SC)) begin
          w_commit    = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!w_valid || !w_match) begin
          w_state_nxt = TRACK;
        end
      end
      default: w_state_nxt = TRACK;
    endcase
  end

  // Frame bookkeeping: a completed frame clears seen/errors, a same-cycle
  // commit is applied after the clear so it is not lost.
  always_comb begin
    w_seen_nxt     = w_full ? '0 : r_seen;
    w_slot_err_nxt = w_full ? '0 : r_slot_err;
    if (w_commit) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (w_idx == IDX_W'(k)) begin
          w_seen_nxt[k]     = 1'b1;
          w_slot_err_nxt[k] = w_dec[4];
        end
      end
    end
  end

  // Sample register, stability counter and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '1;
      r_cnt    <= 8'd0;
      r_state  <= TRACK;
    end else begin
      r_sample <= w_sample;
      r_cnt    <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  end

  // Slot storage and seen mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen     <= '0;
      r_slot_err <= '0;
      r_slot_val <= '0;
    end else begin
      r_seen     <= w_seen_nxt;
      r_slot_err <= w_slot_err_nxt;
      if (w_commit) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (w_idx == IDX_W'(k)) begin
            r_slot_val[4*k +: 4] <= w_dec[3:0];
          end
        end
      end
    end
  end

  // Publish a completed frame; value and err hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      err         <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= w_full;
      if (w_full) begin
        value <= r_slot_val;
        err   <= |r_slot_err;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random display traffic,
// checked by a run-length reference model feeding a frame scoreboard.
module tb_seg7_capture;

  localparam int DIGITS = 4;
  localparam int SC     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        frame_valid;
  logic        err;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
    .value(value), .frame_valid(frame_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic        e;
  } frame_t;

  int          checks = 0;
  int          errors = 0;
  frame_t      exp_q[$];
  int          frames_seen = 0;
  logic [15:0] last_val = '0;
  logic        last_err = 1'b0;
  logic [15:0] exp_v = '0;
  logic        exp_e = 1'b0;

  // reference model state
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_seen;
  logic [3:0]  m_err;
  logic [3:0]  m_nib[4];

  logic [6:0] PAT[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic ref_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
    n = 4'hE;
    e = 1'b1;
    if (s == 7'h7F) begin
      n = 4'hF;
      e = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (PAT[i] == s) begin
        n = 4'(i);
        e = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_prev = '1;
    m_run  = 0;
    m_seen = '0;
    m_err  = '0;
    for (int i = 0; i < 4; i++) m_nib[i] = '0;
  endtask

  // One clock edge of the reference: a digit is taken once, when a run of
  // identical valid samples reaches length SC; a full frame is published on
  // the following edge.
  task automatic model_edge(input logic [3:0] a, input logic [6:0] s);
    logic [3:0] n;
    logic       e;
    int         k;
    bit         valid;
    valid = ($countones(~a) == 1);
    if (m_seen == 4'hF) begin
      exp_q.push_back({{m_nib[3], m_nib[2], m_nib[1], m_nib[0]}, |m_err});
      m_seen = '0;
      m_err  = '0;
    end
    if (!valid) m_run = 0;
    else if ({a, s} == m_prev) m_run++;
    else m_run = 1;
    m_prev = {a, s};
    if (valid && m_run == SC) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) k = i;
      ref_decode(s, n, e);
      m_nib[k]  = n;
      m_err[k]  = e;
      m_seen[k] = 1'b1;
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s);
    an  = a;
    seg = s;
    @(posedge clk);
    model_edge(a, s);
    @(negedge clk);
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    repeat (n) step(a, s);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    dwell(4'b1110, s0, 6);
    dwell(4'b1101, s1, 6);
    dwell(4'b1011, s2, 6);
    dwell(4'b0111, s3, 6);
    dwell(4'b1111, 7'h7F, 3);
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops the expected frame on every pulse and checks that value/err
  // hold between pulses.
  always @(negedge clk) begin
    frame_t f;
    if (!rst_n) begin
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_valid", 32'(frame_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      exp_v = '0;
      exp_e = 1'b0;
    end else begin
      if (frame_valid) begin
        frames_seen++;
        last_val = value;
        last_err = err;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame actual=%0h required=none", value);
        end else begin
          f = exp_q.pop_front();
          exp_v = f.v;
          exp_e = f.e;
        end
      end
      chk("value", 32'(value), 32'(exp_v));
      chk("err", 32'(err), 32'(exp_e));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    logic [3:0] a;
    logic [6:0] s;
    int k;
    rst_n = 1'b0;
    an    = 4'hF;
    seg   = 7'h7F;
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // idle strobes produce nothing
    f0 = frames_seen;
    dwell(4'hF, 7'h7F, 20);
    chk("idle_frames", 32'(frames_seen - f0), 32'd0);

    // basic scan: digits 3,0,1,2
    f0 = frames_seen;
    scan(7'b0110000, 7'b1000000, 7'b1111001, 7'b0100100);
    chk("scan_frames", 32'(frames_seen - f0), 32'd1);
    chk("scan_value", 32'(last_val), 32'h2103);
    chk("scan_err", 32'(last_err), 32'd0);

    // glitch rejection on slot 0
    f0 = frames_seen;
    dwell(4'b1110, 7'b0010010, 3);
    dwell(4'b1110, 7'b0000010, 1);
    dwell(4'b1110, 7'b0010010, 4);
    dwell(4'b1101, 7'b1111001, 6);
    dwell(4'b1011, 7'b0100100, 6);
    dwell(4'b0111, 7'b0110000, 6);
    dwell(4'b1111, 7'h7F, 3);
    chk("glitch_frames", 32'(frames_seen - f0), 32'd1);
    chk("glitch_value", 32'(last_val), 32'h3215);

    // bad pattern and blank, then a clean frame
    f0 = frames_seen;
    scan(7'b1000000, 7'b0101010, 7'b1111111, 7'b1111001);
    chk("bad_value", 32'(last_val), 32'h1FE0);
    chk("bad_err", 32'(last_err), 32'd1);
    scan(7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010);
    chk("clean_value", 32'(last_val), 32'h6789);
    chk("clean_err", 32'(last_err), 32'd0);
    chk("bad_frames", 32'(frames_seen - f0), 32'd2);

    // invalid strobes, then a long single-digit dwell commits once
    f0 = frames_seen;
    dwell(4'b1100, 7'b0000000, 10);
    dwell(4'b0111, 7'b1111001, 10);
    chk("inv_frames", 32'(frames_seen - f0), 32'd0);
    dwell(4'b1110, 7'b0100100, 6);
    dwell(4'b1101, 7'b0110000, 6);
    dwell(4'b1011, 7'b0011001, 6);
    dwell(4'b1111, 7'h7F, 3);
    chk("inv_frames2", 32'(frames_seen - f0), 32'd1);
    chk("inv_value", 32'(last_val), 32'h1432);

    // reset mid-frame discards partial digits
    f0 = frames_seen;
    dwell(4'b1110, 7'b1111000, 6);
    dwell(4'b1101, 7'b1111000, 6);
    dwell(4'b1011, 7'b1111000, 6);
    reset_pulse();
    dwell(4'b0111, 7'b0000000, 6);
    dwell(4'b1111, 7'h7F, 10);
    chk("rst_mid_frames", 32'(frames_seen - f0), 32'd0);
    scan(7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000);
    chk("rst_mid_frames2", 32'(frames_seen - f0), 32'd1);
    chk("rst_mid_value", 32'(last_val), 32'h8765);

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 3);
      a = 4'hF;
      a[k] = 1'b0;
      if ($urandom_range(0, 9) == 0) a = 4'($urandom);
      if ($urandom_range(0, 9) == 0) s = 7'($urandom);
      else if ($urandom_range(0, 9) == 0) s = 7'h7F;
      else s = PAT[$urandom_range(0, 9)];
      dwell(a, s, $urandom_range(1, 8));
    end
    dwell(4'hF, 7'h7F, 4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
